// File: rtl/coef_bank_pkg.sv
// Shared fixed-point format for the coefficient bank.
package coef_bank_pkg;
  localparam int unsigned FP_I = 8;
  localparam int unsigned FP_F = 8;
  localparam int unsigned FP_N = FP_I + FP_F;
endpackage

// File: rtl/coef_bank.sv
// Coefficient register bank: streams coefficients in from memory on load and
// writes a snapshot of the backprop results back out on save.
module coef_bank
  import coef_bank_pkg::*;
#(
  parameter int unsigned N    = FP_N,
  parameter int unsigned NC   = 6,
  parameter int unsigned A    = 8,
  parameter int unsigned BASE = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ld_start,
  input  logic            sv_start,
  input  logic [N-1:0]    mem_din,
  input  logic [N*NC-1:0] upd_in,
  output logic [A-1:0]    mem_addr,
  output logic [N-1:0]    mem_dout,
  output logic [7:0]      mem_we,
  output logic [N*NC-1:0] coef,
  output logic            busy,
  output logic            done
);

  localparam int unsigned KW = $clog2(NC + 1);
  localparam int unsigned CW = N * NC;
  localparam logic [KW-1:0] K_LAST = KW'(NC - 1);
  localparam logic [A-1:0]  A_BASE = A'(BASE);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_DRAIN = 2'd2,
    S_SAVE  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [KW-1:0]   k_q, k_d;
  logic [KW-1:0]   cap_idx_q, cap_idx_d;
  logic            cap_vld_q, cap_vld_d;
  logic [CW-1:0]   coef_q, coef_d;
  logic [CW-1:0]   shadow_q, shadow_d;
  logic [A-1:0]    mem_addr_q, mem_addr_d;
  logic [N-1:0]    mem_dout_q, mem_dout_d;
  logic            we_q, we_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  // Word k of a flat array, MSB-first packing.
  function automatic logic [N-1:0] word_of(input logic [CW-1:0] v, input logic [KW-1:0] i);
    return v[(NC - 1 - 32'(i)) * N +: N];
  endfunction

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    cap_idx_d  = k_q;
    cap_vld_d  = 1'b0;
    coef_d     = coef_q;
    shadow_d   = shadow_q;
    mem_addr_d = mem_addr_q;
    mem_dout_d = mem_dout_q;
    we_d       = we_q;
    busy_d     = busy_q;
    done_d     = 1'b0;

    // Read data lags the address by one cycle; land it in the word issued last cycle.
    if (cap_vld_q) begin
      coef_d[(NC - 1 - 32'(cap_idx_q)) * N +: N] = mem_din;
    end

    case (state_q)
      S_IDLE: begin
        if (sv_start) begin
          shadow_d   = upd_in;
          k_d        = '0;
          mem_addr_d = A_BASE;
          mem_dout_d = word_of(upd_in, '0);
          we_d       = 1'b1;
          busy_d     = 1'b1;
          state_d    = S_SAVE;
        end else if (ld_start) begin
          k_d        = '0;
          mem_addr_d = A_BASE;
          busy_d     = 1'b1;
          state_d    = S_LOAD;
        end
      end
      S_LOAD: begin
        cap_vld_d = 1'b1;
        if (k_q == K_LAST) begin
          mem_addr_d = A_BASE;
          state_d    = S_DRAIN;
        end else begin
          k_d        = k_q + KW'(1);
          mem_addr_d = A_BASE + A'(k_d);
        end
      end
      S_DRAIN: begin
        k_d     = '0;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      S_SAVE: begin
        if (k_q == K_LAST) begin
          k_d        = '0;
          mem_addr_d = A_BASE;
          we_d       = 1'b0;
          busy_d     = 1'b0;
          done_d     = 1'b1;
          state_d    = S_IDLE;
        end else begin
          k_d        = k_q + KW'(1);
          mem_addr_d = A_BASE + A'(k_d);
          mem_dout_d = word_of(shadow_q, k_d);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      k_q        <= '0;
      cap_idx_q  <= '0;
      cap_vld_q  <= 1'b0;
      coef_q     <= '0;
      shadow_q   <= '0;
      mem_addr_q <= A_BASE;
      mem_dout_q <= '0;
      we_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      cap_idx_q  <= cap_idx_d;
      cap_vld_q  <= cap_vld_d;
      coef_q     <= coef_d;
      shadow_q   <= shadow_d;
      mem_addr_q <= mem_addr_d;
      mem_dout_q <= mem_dout_d;
      we_q       <= we_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign mem_addr = mem_addr_q;
  assign mem_dout = mem_dout_q;
  assign mem_we   = {8{we_q}};
  assign coef     = coef_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_coef_bank.sv
// Directed bench for coef_bank: cycle table for load/save plus corner sequences.
module tb_coef_bank;

  localparam int unsigned N = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Instance 0: NC=6, BASE=0
  logic          ld0 = 1'b0, sv0 = 1'b0;
  logic [N-1:0]  din0;
  logic [6*N-1:0] upd0 = '0;
  logic [7:0]    addr0;
  logic [N-1:0]  dout0;
  logic [7:0]    we0;
  logic [6*N-1:0] coef0;
  logic          busy0, done0;

  // Instance 1: NC=4, BASE=10
  logic          ld1 = 1'b0, sv1 = 1'b0;
  logic [N-1:0]  din1;
  logic [4*N-1:0] upd1 = '0;
  logic [7:0]    addr1;
  logic [N-1:0]  dout1;
  logic [7:0]    we1;
  logic [4*N-1:0] coef1;
  logic          busy1, done1;

  coef_bank #(.N(N), .NC(6), .A(8), .BASE(0)) u0 (
    .clk(clk), .rst(rst), .ld_start(ld0), .sv_start(sv0), .mem_din(din0),
    .upd_in(upd0), .mem_addr(addr0), .mem_dout(dout0), .mem_we(we0),
    .coef(coef0), .busy(busy0), .done(done0)
  );

  coef_bank #(.N(N), .NC(4), .A(8), .BASE(10)) u1 (
    .clk(clk), .rst(rst), .ld_start(ld1), .sv_start(sv1), .mem_din(din1),
    .upd_in(upd1), .mem_addr(addr1), .mem_dout(dout1), .mem_we(we1),
    .coef(coef1), .busy(busy1), .done(done1)
  );

  // 1-cycle-latency memories
  logic [N-1:0] mem0 [256];
  logic [N-1:0] mem1 [256];
  logic [N-1:0] rd0 = '0, rd1 = '0;
  assign din0 = rd0;
  assign din1 = rd1;

  always @(posedge clk) begin
    rd0 <= mem0[addr0];
    rd1 <= mem1[addr1];
    if (we0 == 8'hFF) mem0[addr0] <= dout0;
    if (we1 == 8'hFF) mem1[addr1] <= dout1;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        ld;
    logic        sv;
    logic [15:0] upd;
    logic        chk_addr;
    logic [7:0]  addr;
    logic [7:0]  we;
    logic [15:0] dout;
    logic        busy;
    logic        done;
  } vec_t;

  function automatic vec_t mk(input logic ld, input logic sv, input logic [15:0] upd,
                              input logic ca, input logic [7:0] addr, input logic [7:0] we,
                              input logic [15:0] dout, input logic busy, input logic done);
    vec_t v;
    v.ld = ld; v.sv = sv; v.upd = upd; v.chk_addr = ca; v.addr = addr;
    v.we = we; v.dout = dout; v.busy = busy; v.done = done;
    return v;
  endfunction

  task automatic wait_done0(input int maxc, output int cyc);
    cyc = -1;
    for (int c = 1; c <= maxc; c++) begin
      @(posedge clk); #1;
      if (done0) begin
        cyc = c;
        break;
      end
    end
  endtask

  vec_t tbl [15];
  logic [6*N-1:0] coef_load;
  logic [6*N-1:0] coef_a5;
  int cyc;

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem0[i] = 16'h0000;
      mem1[i] = 16'hDEAD;
    end
    for (int k = 0; k < 6; k++) mem0[k] = 16'h0101 + 16'(k);
    for (int k = 0; k < 4; k++) mem1[10 + k] = 16'h00B1 + 16'(k);
    coef_load = {16'h0101, 16'h0102, 16'h0103, 16'h0104, 16'h0105, 16'h0106};
    coef_a5   = {6{16'hA5A5}};

    // Row j: inputs sampled at edge j, expected outputs in cycle j+1.
    tbl[0] = mk(1, 0, 16'h0000, 1, 8'd0, 8'h00, 16'h0000, 1, 0);
    for (int i = 1; i <= 5; i++) tbl[i] = mk(0, 0, 16'h0000, 1, 8'(i), 8'h00, 16'h0000, 1, 0);
    tbl[6]  = mk(0, 0, 16'h0000, 0, 8'd0, 8'h00, 16'h0000, 1, 0);
    tbl[7]  = mk(0, 0, 16'h0000, 1, 8'd0, 8'h00, 16'h0000, 0, 1);
    tbl[8]  = mk(0, 1, 16'h0F0F, 1, 8'd0, 8'hFF, 16'h0F0F, 1, 0);
    for (int i = 9; i <= 13; i++) tbl[i] = mk(0, 0, 16'h0000, 1, 8'(i - 8), 8'hFF, 16'h0F0F, 1, 0);
    tbl[14] = mk(0, 0, 16'h0000, 1, 8'd0, 8'h00, 16'h0F0F, 0, 1);

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_we_async", 128'(we0), 128'h00);
    chk("rst_busy", 128'(busy0), 128'h0);
    @(negedge clk) rst = 1'b0;
    #1;
    chk("rst_addr0", 128'(addr0), 128'd0);
    chk("rst_done", 128'(done0), 128'h0);
    chk("rst_coef", 128'(coef0), 128'h0);
    chk("rst_dout", 128'(dout0), 128'h0);
    chk("idle_addr1_base10", 128'(addr1), 128'd10);

    // Cycle table: load then save on instance 0
    for (int j = 0; j < 15; j++) begin
      @(negedge clk);
      ld0 = tbl[j].ld;
      sv0 = tbl[j].sv;
      upd0 = {6{tbl[j].upd}};
      @(posedge clk); #1;
      if (tbl[j].chk_addr) chk($sformatf("tbl%0d_addr", j), 128'(addr0), 128'(tbl[j].addr));
      chk($sformatf("tbl%0d_we", j), 128'(we0), 128'(tbl[j].we));
      chk($sformatf("tbl%0d_dout", j), 128'(dout0), 128'(tbl[j].dout));
      chk($sformatf("tbl%0d_busy", j), 128'(busy0), 128'(tbl[j].busy));
      chk($sformatf("tbl%0d_done", j), 128'(done0), 128'(tbl[j].done));
      if (j == 7) chk("load_coef", 128'(coef0), 128'(coef_load));
    end
    @(negedge clk);
    ld0 = 1'b0; sv0 = 1'b0; upd0 = '0;
    chk("save_coef_unchanged", 128'(coef0), 128'(coef_load));
    for (int k = 0; k < 6; k++) chk($sformatf("save_mem%0d", k), 128'(mem0[k]), 128'h0F0F);

    // Simultaneous starts: save wins, late ld_start ignored
    @(negedge clk);
    ld0 = 1'b1; sv0 = 1'b1; upd0 = coef_a5;
    @(posedge clk); #1;
    chk("both_c1_we", 128'(we0), 128'hFF);
    chk("both_c1_busy", 128'(busy0), 128'h1);
    for (int c = 2; c <= 7; c++) begin
      @(negedge clk);
      ld0 = (c == 3); sv0 = 1'b0; upd0 = '0;
      @(posedge clk); #1;
      if (c < 7) begin
        chk($sformatf("both_c%0d_we", c), 128'(we0), 128'hFF);
        chk($sformatf("both_c%0d_addr", c), 128'(addr0), 128'(c - 1));
      end else begin
        chk("both_done", 128'(done0), 128'h1);
        chk("both_busy_low", 128'(busy0), 128'h0);
      end
    end
    @(negedge clk) ld0 = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      chk("ld_during_save_ignored", 128'(busy0), 128'h0);
    end
    chk("both_coef_unchanged", 128'(coef0), 128'(coef_load));
    for (int k = 0; k < 6; k++) chk($sformatf("both_mem%0d", k), 128'(mem0[k]), 128'hA5A5);

    // Async reset in LOAD cycle 3, then a clean reload
    @(negedge clk) ld0 = 1'b1;
    @(posedge clk);
    @(negedge clk) ld0 = 1'b0;
    @(posedge clk);
    @(posedge clk); #2;
    chk("pre_rst_busy", 128'(busy0), 128'h1);
    rst = 1'b1;
    #1;
    chk("midload_rst_busy", 128'(busy0), 128'h0);
    chk("midload_rst_we", 128'(we0), 128'h00);
    chk("midload_rst_coef", 128'(coef0), 128'h0);
    chk("midload_rst_addr", 128'(addr0), 128'd0);
    @(negedge clk) rst = 1'b0;
    @(negedge clk) ld0 = 1'b1;
    @(negedge clk) ld0 = 1'b0;
    wait_done0(20, cyc);
    chk("reload_done_cycle", 128'(cyc), 128'd7);
    chk("reload_coef", 128'(coef0), 128'(coef_a5));

    // Instance 1: BASE=10, NC=4
    @(negedge clk) ld1 = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk); #1;
      if (c == 1) begin
        @(negedge clk) ld1 = 1'b0;
        chk("b10_addr_c1", 128'(addr1), 128'd10);
      end else if (c <= 4) begin
        chk($sformatf("b10_addr_c%0d", c), 128'(addr1), 128'(9 + c));
      end else if (c == 6) begin
        chk("b10_done", 128'(done1), 128'h1);
        chk("b10_addr_idle", 128'(addr1), 128'd10);
      end
      if (busy1 && (addr1 < 8'd10 || addr1 > 8'd13))
        chk("b10_addr_range", 128'(addr1), 128'd10);
    end
    chk("b10_coef", 128'(coef1), 128'({16'h00B1, 16'h00B2, 16'h00B3, 16'h00B4}));
    @(negedge clk);
    sv1 = 1'b1; upd1 = {4{16'h5A5A}};
    @(negedge clk);
    sv1 = 1'b0; upd1 = '0;
    repeat (6) @(negedge clk);
    chk("b10_save_busy", 128'(busy1), 128'h0);
    chk("b10_mem9", 128'(mem1[9]), 128'hDEAD);
    chk("b10_mem14", 128'(mem1[14]), 128'hDEAD);
    for (int k = 10; k <= 13; k++) chk($sformatf("b10_mem%0d", k), 128'(mem1[k]), 128'h5A5A);

    // Async reset mid-save drops the write enable at once, no done
    @(negedge clk);
    sv0 = 1'b1; upd0 = {6{16'h1234}};
    @(negedge clk);
    sv0 = 1'b0; upd0 = '0;
    @(posedge clk); #2;
    chk("pre_rst_save_we", 128'(we0), 128'hFF);
    rst = 1'b1;
    #1;
    chk("midsave_rst_we", 128'(we0), 128'h00);
    chk("midsave_rst_done", 128'(done0), 128'h0);
    @(negedge clk) rst = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      chk("post_rst_no_done", 128'(done0), 128'h0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
